// File: rtl/fme_pkg.sv
// Shared types, candidate ordering and offset helpers for the FME sequencer.
package fme_pkg;

  localparam int unsigned SAD_W_DEF = 16;
  localparam int unsigned IDX_W     = 4;
  localparam logic [3:0]  CENTRE    = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_IP,
    S_H_SAD,
    S_Q_IP,
    S_Q_SAD,
    S_FIN
  } state_t;

  // 3x3 row-major neighbours, centre excluded
  localparam logic [7:0][3:0] CAND_ORDER = {4'd8, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0};

  // Column offset of a 3x3 index, two's complement in 3 bits
  function automatic logic [2:0] idx_dx(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: return 3'b111;
      4'd1, 4'd4, 4'd7: return 3'b000;
      default:          return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] idx_dy(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return 3'b111;
      4'd3, 4'd4, 4'd5: return 3'b000;
      default:          return 3'b001;
    endcase
  endfunction

  // Quarter-pel offset: half-pel step counts double
  function automatic logic [2:0] mv_comb(input logic [2:0] h, input logic [2:0] q);
    return {h[1:0], 1'b0} + q;
  endfunction

endpackage

// File: rtl/fme_min_track.sv
// Running minimum of SAD responses with its candidate index, shared by both phases.
module fme_min_track
  import fme_pkg::*;
#(
  parameter int unsigned SAD_W = SAD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [SAD_W-1:0] i_load_sad,
  input  logic             i_rebase,
  input  logic             i_upd,
  input  logic [SAD_W-1:0] i_sad,
  input  logic [3:0]       i_idx,
  output logic [SAD_W-1:0] o_min_sad,
  output logic [3:0]       o_min_idx,
  output logic [3:0]       o_nxt_idx_c
);

  logic [SAD_W-1:0] r_min_sad;
  logic [3:0]       r_min_idx;
  logic             w_win;

  // Strict compare: ties keep the earlier (centre first) winner
  assign w_win       = i_upd && (i_sad < r_min_sad);
  assign o_nxt_idx_c = w_win ? i_idx : r_min_idx;
  assign o_min_sad   = r_min_sad;
  assign o_min_idx   = r_min_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min_sad <= '0;
      r_min_idx <= '0;
    end else if (i_load) begin
      r_min_sad <= i_load_sad;
      r_min_idx <= CENTRE;
    end else if (i_rebase) begin
      r_min_idx <= CENTRE;
    end else if (w_win) begin
      r_min_sad <= i_sad;
      r_min_idx <= i_idx;
    end
  end

endmodule

// File: rtl/fme_sched.sv
// Fractional ME sequencer: half-pel then quarter-pel search around the integer best,
// sharing one interpolator and one SAD unit.
module fme_sched
  import fme_pkg::*;
#(
  parameter int unsigned SAD_W   = SAD_W_DEF,
  parameter int unsigned LAT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SAD_W-1:0] int_sad,
  output logic             busy,
  output logic             ip_start,
  output logic             ip_quat,
  output logic [3:0]       ip_best,
  input  logic             ip_done,
  output logic             cand_valid,
  output logic [3:0]       cand_idx,
  input  logic             cand_ready,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_val,
  output logic             done,
  output logic             err,
  output logic [2:0]       mv_dx,
  output logic [2:0]       mv_dy,
  output logic [SAD_W-1:0] best_sad
);

  localparam int unsigned WD_W = $clog2(LAT_MAX + 1);

  state_t           r_state, w_state_nx;
  logic [3:0]       r_iss_cnt, w_iss_nx;
  logic [2:0]       r_rsp_cnt, w_rsp_nx;
  logic [WD_W-1:0]  r_wd, w_wd_nx;
  logic             r_abort, w_abort_nx;
  logic [SAD_W-1:0] r_int_sad;
  logic             r_busy, r_ip_start, r_ip_quat, r_cand_valid, r_done, r_err;
  logic [3:0]       r_ip_best, r_cand_idx;
  logic [2:0]       r_mv_dx, r_mv_dy;
  logic [SAD_W-1:0] r_best_sad;

  logic             w_hs, w_rsp, w_ipd, w_event, w_active, w_timeout;
  logic             w_sad_ph, w_ip_ph, w_pend, w_load, w_rebase;
  logic             w_ip_start_nx, w_cand_valid_nx;
  logic [3:0]       w_cand_idx_nx, w_rsp_idx, w_nxt_idx, w_min_idx;
  logic [SAD_W-1:0] w_min_sad;

  assign w_sad_ph  = (r_state == S_H_SAD) || (r_state == S_Q_SAD);
  assign w_ip_ph   = (r_state == S_H_IP)  || (r_state == S_Q_IP);
  assign w_active  = w_sad_ph || w_ip_ph;
  assign w_hs      = r_cand_valid && cand_ready;
  // Responses arrive in issue order; stray ones with nothing outstanding are dropped
  assign w_pend    = (r_iss_cnt != {1'b0, r_rsp_cnt});
  assign w_rsp     = sad_valid && w_sad_ph && w_pend;
  assign w_ipd     = ip_done && w_ip_ph;
  assign w_event   = w_hs || w_rsp || w_ipd;
  assign w_timeout = w_active && !w_event && (r_wd == WD_W'(LAT_MAX - 1));
  assign w_rsp_idx = CAND_ORDER[r_rsp_cnt];

  fme_min_track #(.SAD_W(SAD_W)) u_min (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_sad  (int_sad),
    .i_rebase    (w_rebase),
    .i_upd       (w_rsp),
    .i_sad       (sad_val),
    .i_idx       (w_rsp_idx),
    .o_min_sad   (w_min_sad),
    .o_min_idx   (w_min_idx),
    .o_nxt_idx_c (w_nxt_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_abort_nx = r_abort;
    w_load     = 1'b0;
    w_rebase   = 1'b0;
    w_iss_nx   = r_iss_cnt + 4'(w_hs);
    w_rsp_nx   = r_rsp_cnt + 3'(w_rsp);
    w_wd_nx    = (w_active && !w_event) ? r_wd + WD_W'(1) : '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_H_IP;
          w_load     = 1'b1;
          w_abort_nx = 1'b0;
        end
      end
      S_H_IP, S_Q_IP: begin
        w_rebase = (r_state == S_Q_IP);
        if (w_ipd) begin
          w_state_nx = (r_state == S_H_IP) ? S_H_SAD : S_Q_SAD;
        end else if (w_timeout) begin
          w_state_nx = S_FIN;
          w_abort_nx = 1'b1;
        end
      end
      S_H_SAD, S_Q_SAD: begin
        if (w_rsp && (r_rsp_cnt == 3'd7)) begin
          w_state_nx = (r_state == S_H_SAD) ? S_Q_IP : S_FIN;
        end else if (w_timeout) begin
          w_state_nx = S_FIN;
          w_abort_nx = 1'b1;
        end
      end
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Each state starts with fresh issue/response/watchdog counts
    if (w_state_nx != r_state) begin
      w_iss_nx = '0;
      w_rsp_nx = '0;
      w_wd_nx  = '0;
    end
    w_ip_start_nx   = (w_state_nx != r_state) &&
                      ((w_state_nx == S_H_IP) || (w_state_nx == S_Q_IP));
    w_cand_valid_nx = ((w_state_nx == S_H_SAD) || (w_state_nx == S_Q_SAD)) &&
                      (w_iss_nx < 4'd8);
    w_cand_idx_nx   = w_cand_valid_nx ? CAND_ORDER[w_iss_nx[2:0]] : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_iss_cnt    <= '0;
      r_rsp_cnt    <= '0;
      r_wd         <= '0;
      r_abort      <= 1'b0;
      r_int_sad    <= '0;
      r_busy       <= 1'b0;
      r_ip_start   <= 1'b0;
      r_ip_quat    <= 1'b0;
      r_ip_best    <= '0;
      r_cand_valid <= 1'b0;
      r_cand_idx   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mv_dx      <= '0;
      r_mv_dy      <= '0;
      r_best_sad   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_iss_cnt    <= w_iss_nx;
      r_rsp_cnt    <= w_rsp_nx;
      r_wd         <= w_wd_nx;
      r_abort      <= w_abort_nx;
      r_busy       <= (w_state_nx != S_IDLE);
      r_ip_start   <= w_ip_start_nx;
      r_ip_quat    <= (w_state_nx == S_Q_IP) || (w_state_nx == S_Q_SAD);
      r_cand_valid <= w_cand_valid_nx;
      r_cand_idx   <= w_cand_idx_nx;
      r_done       <= (r_state == S_FIN);
      r_err        <= (r_state == S_FIN) && r_abort;
      if (w_load) r_int_sad <= int_sad;
      if ((r_state == S_H_SAD) && (w_state_nx == S_Q_IP)) begin
        r_ip_best <= w_nxt_idx;
      end else if (r_state == S_FIN) begin
        r_ip_best <= '0;
      end
      if (r_state == S_FIN) begin
        r_mv_dx    <= r_abort ? 3'd0 : mv_comb(idx_dx(r_ip_best), idx_dx(w_min_idx));
        r_mv_dy    <= r_abort ? 3'd0 : mv_comb(idx_dy(r_ip_best), idx_dy(w_min_idx));
        r_best_sad <= r_abort ? r_int_sad : w_min_sad;
      end
    end
  end

  assign busy       = r_busy;
  assign ip_start   = r_ip_start;
  assign ip_quat    = r_ip_quat;
  assign ip_best    = r_ip_best;
  assign cand_valid = r_cand_valid;
  assign cand_idx   = r_cand_idx;
  assign done       = r_done;
  assign err        = r_err;
  assign mv_dx      = r_mv_dx;
  assign mv_dy      = r_mv_dy;
  assign best_sad   = r_best_sad;

endmodule
